// File: rtl/cvxif_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_wb_queue
// Brief    : CVXIF result queue in front of the scoreboard writeback port,
//            with empty-queue bypass, sticky overflow flag and flush.
// Revision : 1.0 - initial release
// ============================================================================
module cvxif_wb_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [TRANS_ID_BITS-1:0]     in_trans_id_i,
    input  logic [XLEN-1:0]              in_result_i,
    input  logic                         in_we_i,
    input  logic                         in_ex_valid_i,
    input  logic [XLEN-1:0]              in_ex_cause_i,
    input  logic [XLEN-1:0]              in_ex_tval_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]     wb_trans_id_o,
    output logic [XLEN-1:0]              wb_result_o,
    output logic                         wb_we_o,
    output logic                         wb_ex_valid_o,
    output logic [XLEN-1:0]              wb_ex_cause_o,
    output logic [XLEN-1:0]              wb_ex_tval_o,
    output logic                         overflow_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = TRANS_ID_BITS + 3*XLEN + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_in_entry;
    logic [EW-1:0] w_out_entry;

    assign w_empty    = (count_q == '0);
    assign in_ready_o = (count_q < CW'(DEPTH));
    assign w_in_entry = {in_trans_id_i, in_result_i, in_we_i,
                         in_ex_valid_i, in_ex_cause_i, in_ex_tval_i};

    // Bypass beats accepted straight through an empty queue never touch storage
    assign w_push = in_valid_i & in_ready_o & ~flush_i & ~(w_empty & wb_ready_i);
    assign w_pop  = ~w_empty & wb_ready_i & ~flush_i;

    assign wb_valid_o = (~w_empty | in_valid_i) & ~flush_i;

    always_comb begin
        w_out_entry = '0;
        if (wb_valid_o) begin
            w_out_entry = w_empty ? w_in_entry : mem_q[rd_ptr_q];
        end
    end

    assign {wb_trans_id_o, wb_result_o, wb_we_o,
            wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o} = w_out_entry;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_d = count_q - CW'(1);
            end
            // Illegal-instruction results ignore ready, so a drop must be remembered
            if (in_valid_i && !in_ready_o) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            mem_q[wr_ptr_q] <= w_in_entry;
        end
    end

    assign overflow_o = overflow_q;
    assign count_o    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cvxif_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_wb_queue
// Brief    : Directed bench for cvxif_wb_queue against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvxif_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TIDW  = 3;
    localparam int unsigned XLEN  = 64;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, in_we, in_exv;
    logic [TIDW-1:0] in_id;
    logic [XLEN-1:0] in_res, in_cause, in_tval;
    logic            wb_valid, wb_ready, wb_we, wb_exv, overflow;
    logic [TIDW-1:0] wb_id;
    logic [XLEN-1:0] wb_res, wb_cause, wb_tval;
    logic [2:0]      count;

    typedef struct {
        logic [TIDW-1:0] id;
        logic [XLEN-1:0] res;
        logic            we;
        logic            exv;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } ent_t;

    ent_t            mq[$];
    logic [TIDW-1:0] log_ids[$];
    bit              m_ov;
    bit              model_ok = 1'b0;
    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    cvxif_wb_queue #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIDW), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_trans_id_i(in_id),
        .in_result_i(in_res), .in_we_i(in_we), .in_ex_valid_i(in_exv),
        .in_ex_cause_i(in_cause), .in_ex_tval_i(in_tval),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_trans_id_o(wb_id),
        .wb_result_o(wb_res), .wb_we_o(wb_we), .wb_ex_valid_o(wb_exv),
        .wb_ex_cause_o(wb_cause), .wb_ex_tval_o(wb_tval),
        .overflow_o(overflow), .count_o(count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Queue-level model: state advances on the rising edge from the rules.
    always @(posedge clk) begin
        bit acc, taken;
        if (rst) begin
            mq.delete();
            m_ov     = 1'b0;
            model_ok = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else if (model_ok) begin
            acc   = in_valid && (mq.size() < DEPTH);
            taken = wb_ready && (mq.size() > 0 || in_valid);
            if (in_valid && !acc) m_ov = 1'b1;
            if (mq.size() == 0) begin
                if (taken) log_ids.push_back(in_id);
                else if (acc) mq.push_back('{in_id, in_res, in_we, in_exv, in_cause, in_tval});
            end else begin
                if (taken) log_ids.push_back(mq.pop_front().id);
                if (acc) mq.push_back('{in_id, in_res, in_we, in_exv, in_cause, in_tval});
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        ent_t e;
        bit   ev;
        if (model_ok) begin
            e  = '{0, 0, 0, 0, 0, 0};
            ev = !flush && (mq.size() > 0 || in_valid);
            if (ev) e = (mq.size() > 0) ? mq[0] : '{in_id, in_res, in_we, in_exv, in_cause, in_tval};
            chk("m_valid", wb_valid, ev);
            chk("m_ready", in_ready, mq.size() < DEPTH);
            chk("m_count", count, mq.size());
            chk("m_ovf", overflow, m_ov);
            chk("m_id", wb_id, e.id);
            chk("m_res", wb_res, e.res);
            chk("m_we", wb_we, e.we);
            chk("m_exv", wb_exv, e.exv);
            chk("m_cause", wb_cause, e.cause);
            chk("m_tval", wb_tval, e.tval);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TIDW-1:0] id, input logic [XLEN-1:0] res,
                        input logic we, input logic exv, input logic [XLEN-1:0] cause);
        in_valid = 1'b1; in_id = id; in_res = res; in_we = we;
        in_exv = exv; in_cause = cause; in_tval = {32'h0, 29'h0, id} ^ 64'h1000;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_id = '0; in_res = '0; in_we = 1'b0;
        in_exv = 1'b0; in_cause = '0; in_tval = '0;
    endtask

    initial begin
        int ls;
        bit saw5;
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0; #2;
        chk("rst_count", count, 0);
        chk("rst_valid", wb_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_ovf", overflow, 0);

        // Bypass through an empty queue
        tick(); push(3'd2, 64'hDEAD, 1'b1, 1'b0, '0); wb_ready = 1'b1; #2;
        chk("byp_valid", wb_valid, 1);
        chk("byp_id", wb_id, 2);
        chk("byp_res", wb_res, 64'hDEAD);
        chk("byp_we", wb_we, 1);
        tick(); idle(); #2;
        chk("byp_count", count, 0);

        // Fill under backpressure, then drain in order
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); push(TIDW'(i), 64'(i * 3), 1'b1, 1'b0, '0); #2; end
        tick(); idle(); wb_ready = 1'b1; #2;
        chk("fill_count", count, 4);
        chk("fill_ready", in_ready, 0);
        chk("drain_id0", wb_id, 0);
        for (int i = 1; i < 4; i++) begin tick(); #2; chk("drain_id", wb_id, i); end
        tick(); wb_ready = 1'b0; #2;
        chk("drain_count", count, 0);

        // Steady state at occupancy 2 across pointer wrap
        tick(); push(3'd0, 64'h100, 1'b0, 1'b0, '0); #2;
        tick(); push(3'd1, 64'h101, 1'b0, 1'b0, '0); #2;
        for (int k = 0; k < 10; k++) begin
            tick(); push(TIDW'((2 + k) % 8), 64'(16'h100 + 2 + k), 1'b0, 1'b0, '0); wb_ready = 1'b1; #2;
            chk("wrap_count", count, 2);
            chk("wrap_id", wb_id, k % 8);
        end
        tick(); idle(); #2;
        chk("wrap_tail_count", count, 2);
        tick(); #2;
        tick(); wb_ready = 1'b0; #2;
        chk("wrap_end_count", count, 0);
        chk("wrap_ovf", overflow, 0);

        // Overflow on a full queue; dropped beat must never surface
        ls = log_ids.size();
        for (int i = 0; i < 4; i++) begin tick(); push(TIDW'(i), 64'h200, 1'b1, 1'b0, '0); #2; end
        tick(); push(3'd5, 64'h0, 1'b0, 1'b1, 64'd2); #2;
        chk("ovf_ready", in_ready, 0);
        tick(); idle(); #2;
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        wb_ready = 1'b1;
        repeat (4) tick();
        wb_ready = 1'b0; #2;
        chk("ovf_drain_count", count, 0);
        saw5 = 1'b0;
        for (int i = ls; i < log_ids.size(); i++) if (log_ids[i] == 3'd5) saw5 = 1'b1;
        chk("ovf_drained_n", log_ids.size() - ls, 4);
        chk("ovf_no_id5", saw5, 0);
        tick(); flush = 1'b1; #2;
        tick(); flush = 1'b0; #2;
        chk("ovf_sticky", overflow, 1);

        // Flush with concurrent push and pop
        for (int i = 1; i < 4; i++) begin tick(); push(TIDW'(i), 64'h300, 1'b0, 1'b0, '0); #2; end
        tick(); push(3'd6, 64'h366, 1'b1, 1'b0, '0); wb_ready = 1'b1; flush = 1'b1; #2;
        chk("fl_valid", wb_valid, 0);
        chk("fl_res", wb_res, 0);
        ls = log_ids.size();
        tick(); idle(); flush = 1'b0; #2;
        chk("fl_count", count, 0);
        chk("fl_valid_next", wb_valid, 0);
        chk("fl_ready", in_ready, 1);
        tick(); #2;
        chk("fl_no_reappear", log_ids.size() - ls, 0);

        // Reset in the middle of operation
        wb_ready = 1'b0;
        tick(); push(3'd4, 64'h400, 1'b1, 1'b0, '0); #2;
        tick(); push(3'd5, 64'h405, 1'b1, 1'b0, '0); #2;
        tick(); idle(); rst = 1'b1; #2;
        chk("mid_pre_count", count, 2);
        tick(); rst = 1'b0; #2;
        chk("mid_count", count, 0);
        chk("mid_valid", wb_valid, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_ready", in_ready, 1);
        tick(); push(3'd7, 64'h77, 1'b1, 1'b1, 64'd11); wb_ready = 1'b1; #2;
        chk("mid_byp_valid", wb_valid, 1);
        chk("mid_byp_id", wb_id, 7);
        chk("mid_byp_exv", wb_exv, 1);
        tick(); idle(); #2;
        chk("mid_byp_count", count, 0);

        // Full queue with ready high: pop only, push is rejected and flagged
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); push(TIDW'(i + 2), 64'h500, 1'b0, 1'b0, '0); #2; end
        tick(); push(3'd1, 64'h511, 1'b0, 1'b0, '0); wb_ready = 1'b1; #2;
        chk("full_pp_id", wb_id, 2);
        tick(); idle(); #2;
        chk("full_pp_count", count, 3);
        chk("full_pp_ovf", overflow, 1);
        repeat (5) tick();
        #2;
        chk("final_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
